ex_mem_stage: RTL

//  Execute->memory pipeline register placed directly downstream of the 64-bit ALU.

---
 rtl/ex_mem_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute->memory pipeline register behind the 64-bit ALU.
// It holds one beat of ALU result, control and store data behind a valid/ready
// handshake, and it keeps the NZCV flags.
// Optional feature: define DIV_ZERO_TRAP_EN to add the div_zero_q output. A
// divide beat (op 0011) with a zero divisor then has its register write
// suppressed and does not update the flags.
module ex_mem_stage #(
  parameter int WIDTH      = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      firstInput,
  input  logic [WIDTH-1:0]      secondInput,
  input  logic [3:0]            operation,
  input  logic [WIDTH-1:0]      ALU_Out,
  input  logic                  CarryOut,
  input  logic                  set_flags,
  input  logic [REG_ADDR_W-1:0] rd_in,
  input  logic                  reg_write_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [WIDTH-1:0]      store_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result_q,
  output logic [REG_ADDR_W-1:0] rd_q,
  output logic                  reg_write_q,
  output logic                  mem_read_q,
  output logic                  mem_write_q,
  output logic [WIDTH-1:0]      store_data_q,
  output logic [3:0]            flags_q,
`ifdef DIV_ZERO_TRAP_EN
  output logic                  div_zero_q,
`endif
  output logic                  zero_q
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_DIV = 4'b0011;

  logic accept;
  logic div_trap;
  logic flag_we;

  // NZCV from the ALU operands and result. Carry comes from the ALU for ADD.
  // For SUB, carry is recomputed as "no borrow".
  function automatic logic [3:0] nzcv(input logic [WIDTH-1:0] a,
                                      input logic [WIDTH-1:0] b,
                                      input logic [WIDTH-1:0] r,
                                      input logic             carry,
                                      input logic [3:0]       op);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic signed [WIDTH-1:0] sr;
    logic n;
    logic z;
    logic c;
    logic v;
    sa = a;
    sb = b;
    sr = r;
    n  = sr < 0;
    z  = (r == '0);
    c  = 1'b0;
    v  = 1'b0;
    if (op == OP_ADD) begin
      c = carry;
      v = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
    end else if (op == OP_SUB) begin
      c = (a >= b);
      v = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    end
    return {n, z, c, v};
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

`ifdef DIV_ZERO_TRAP_EN
  assign div_trap = (operation == OP_DIV) && (secondInput == '0);
`else
  assign div_trap = 1'b0;
`endif

  assign flag_we = accept && set_flags && !div_trap;

  // Valid bit: flush kills everything. An accept loads a beat. A drain without an accept empties the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Beat payload: loaded only on accept, otherwise held (also after a drain).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q     <= '0;
      zero_q       <= 1'b0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      store_data_q <= '0;
    end else if (accept) begin
      result_q     <= ALU_Out;
      zero_q       <= (ALU_Out == '0);
      rd_q         <= rd_in;
      reg_write_q  <= reg_write_in && !div_trap;
      mem_read_q   <= mem_read_in;
      mem_write_q  <= mem_write_in;
      store_data_q <= store_data;
    end
  end

  // Flags: updated only by an accepted flag-setting beat; they survive a flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (flag_we) begin
      flags_q <= nzcv(firstInput, secondInput, ALU_Out, CarryOut, operation);
    end
  end

`ifdef DIV_ZERO_TRAP_EN
  // Divide-by-zero marker travels with the beat it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_zero_q <= 1'b0;
    end else if (accept) begin
      div_zero_q <= div_trap;
    end
  end
`endif

endmodule
